// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST test-pattern generator.
// Holds the FSM state encoding and the default LFSR geometry.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } tpg_state_t;

    localparam int         TPG_DEFAULT_WIDTH = 4;
    localparam logic [3:0] TPG_DEFAULT_TAPS  = 4'b1100;

endpackage

// File: rtl/bist_lfsr.sv
// Fibonacci LFSR with synchronous load and single-step advance.
// A zero load value is replaced by 1 so the register never locks up.
module bist_lfsr #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    logic feedback;

    assign feedback = ^(value & TAPS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= (loadValue == '0) ? WIDTH'(1) : loadValue;
        end else if (advance) begin
            value <= {value[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST stimulus generator: seeds an LFSR on start and streams a
// programmed number of patterns over valid/ready, then pulses done.
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter int               WIDTH = TPG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TPG_DEFAULT_TAPS),
    parameter int               CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    input  logic             pattern_ready,
    output logic             pattern_last,
    output logic             busy,
    output logic             done
);

    tpg_state_t       state;
    tpg_state_t       nextState;
    logic [CNT_W-1:0] remaining;
    logic             accept;
    logic             handshake;
    logic             lastOne;

    assign accept    = (state == IDLE) && start;
    // Abort wins over a same-cycle handshake: nothing is consumed.
    assign handshake = (state == RUN) && pattern_ready && !abort;
    assign lastOne   = (remaining == CNT_W'(1));

    bist_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) lfsr (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .loadValue (seed),
        .advance   (handshake),
        .value     (pattern)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = (num_patterns == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    nextState = IDLE;
                end else if (pattern_ready && lastOne) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (accept) begin
            remaining <= num_patterns;
        end else if (handshake && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign pattern_valid = (state == RUN);
    assign busy          = (state == RUN);
    assign pattern_last  = (state == RUN) && lastOne;
    assign done          = (state == DONE);

endmodule
